alu_op_sequencer: RTL and testbench

- Sequences the 8-bit MiniCPU ALU datapath: accepts one operation request at a time over a valid/ready handshake and drives the ALU operand buses.
- Selects and captures the result bus for the opcode; multi-cycle shifts and a shift-add multiply iterate over the ALU's single-step shifter and adder.
- Returns the result, carry and overflow over a valid/ready response channel.
- Sits between the CPU control unit and the combinational ALU.

---
 rtl/alu_op_sequencer_if.sv | 50 +++++
 rtl/alu_op_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_if
//   Bundles the request channel, the response channel and the ALU operand and
//   result buses that connect the alu_op_sequencer to its neighbours.
//   modport master : the environment side. It is the CPU control unit plus the
//                    combinational ALU. It drives requests, rsp_ready and the
//                    ALU result buses.
//   modport slave  : the sequencer side. It drives req_ready, the ALU operand
//                    buses and the response fields.
// -----------------------------------------------------------------------------
interface alu_op_sequencer_if;
   // request channel
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic [2:0] req_cnt;
   // ALU operand / result buses
   logic [7:0] alu_in1;
   logic [7:0] alu_in2;
   logic [8:0] alu_add;
   logic [7:0] alu_shl;
   logic [7:0] alu_shr;
   logic [7:0] alu_and;
   logic [7:0] alu_or;
   logic [7:0] alu_comp;
   logic       alu_ov2;
   // response channel
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_carry;
   logic       rsp_ov;
   logic       rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, req_cnt, rsp_ready,
             alu_add, alu_shl, alu_shr, alu_and, alu_or, alu_comp, alu_ov2,
      input  req_ready, alu_in1, alu_in2,
             rsp_valid, rsp_data, rsp_carry, rsp_ov, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_cnt, rsp_ready,
             alu_add, alu_shl, alu_shr, alu_and, alu_or, alu_comp, alu_ov2,
      output req_ready, alu_in1, alu_in2,
             rsp_valid, rsp_data, rsp_carry, rsp_ov, rsp_err
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//   Sequences the 8-bit MiniCPU ALU datapath. The block accepts one operation
//   at a time over a valid/ready handshake. It drives the registered ALU
//   operand buses and captures the result bus for the opcode. Shifts and a
//   shift-add multiply are built by iterating over the single-step ALU shifter
//   and adder. The result, carry, overflow and error flags are returned over a
//   valid/ready response channel.
//
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous, active-high reset
//     bus   - alu_op_sequencer_if.slave (request, ALU buses, response)
//     busy  - high while an operation is executing or its response is pending
//
//   Opcodes: 0 ADD, 1 SHL, 2 SHR, 3 AND, 4 OR, 5 COMP, 6 MUL, 7 reserved
//            (the reserved opcode answers with data 0 and rsp_err).
//
//   Optional feature, macro ALU_SEQ_EARLY_TERM_EN:
//     MUL stops once the multiplier register has drained to zero.
//     SHL/SHR stop once the shifted operand becomes zero.
//     Results and flags are unchanged by this feature; only latency shrinks.
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int MAX_SHIFT = 7
) (
   input  logic                clk,
   input  logic                reset,
   alu_op_sequencer_if.slave   bus,
   output logic                busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SHL  = 3'd1;
   localparam logic [2:0] OP_SHR  = 3'd2;
   localparam logic [2:0] OP_AND  = 3'd3;
   localparam logic [2:0] OP_OR   = 3'd4;
   localparam logic [2:0] OP_COMP = 3'd5;
   localparam logic [2:0] OP_MUL  = 3'd6;

   localparam logic [2:0] MAX_CNT = 3'(MAX_SHIFT);

   logic [1:0] state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [7:0] opnd1_q, opnd1_d;
   logic [7:0] opnd2_q, opnd2_d;
   logic [3:0] cnt_q, cnt_d;       // remaining steps; MUL needs 8, so 4 bits
   logic [7:0] acc_q, acc_d;
   logic [7:0] mcand_q, mcand_d;
   logic [7:0] mult_q, mult_d;
   logic [7:0] alu_in1_q, alu_in1_d;
   logic [7:0] alu_in2_q, alu_in2_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rsp_carry_q, rsp_carry_d;
   logic       rsp_ov_q, rsp_ov_d;
   logic       rsp_err_q, rsp_err_d;

   logic       last_step;
   logic [7:0] shift_nxt;
   logic [7:0] acc_nxt;
   logic [7:0] mult_nxt;
   logic [2:0] cnt_sat;

   assign cnt_sat = (bus.req_cnt > MAX_CNT) ? MAX_CNT : bus.req_cnt;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      opnd1_d     = opnd1_q;
      opnd2_d     = opnd2_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mult_d      = mult_q;
      rsp_data_d  = rsp_data_q;
      rsp_carry_d = rsp_carry_q;
      rsp_ov_d    = rsp_ov_q;
      rsp_err_d   = rsp_err_q;
      last_step   = 1'b0;
      shift_nxt   = (op_q == OP_SHL) ? bus.alu_shl : bus.alu_shr;
      acc_nxt     = mult_q[0] ? bus.alu_add[7:0] : acc_q;
      mult_nxt    = mult_q >> 1;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               op_d        = bus.req_op;
               opnd1_d     = bus.req_a;
               opnd2_d     = bus.req_b;
               acc_d       = 8'h00;
               mcand_d     = bus.req_a;
               mult_d      = bus.req_b;
               rsp_carry_d = 1'b0;
               rsp_ov_d    = 1'b0;
               rsp_err_d   = 1'b0;
               case (bus.req_op)
                  OP_SHL, OP_SHR: cnt_d = {1'b0, cnt_sat};
                  OP_MUL:         cnt_d = 4'd8;
                  default:        cnt_d = 4'd1;
               endcase
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            case (op_q)
               OP_ADD: begin
                  rsp_data_d  = bus.alu_add[7:0];
                  rsp_carry_d = bus.alu_add[8];
                  last_step   = 1'b1;
               end
               OP_AND: begin
                  rsp_data_d = bus.alu_and;
                  last_step  = 1'b1;
               end
               OP_OR: begin
                  rsp_data_d = bus.alu_or;
                  last_step  = 1'b1;
               end
               OP_COMP: begin
                  rsp_data_d = bus.alu_comp;
                  last_step  = 1'b1;
               end
               OP_SHL, OP_SHR: begin
                  if (cnt_q == 4'd0) begin
                     rsp_data_d = opnd2_q;
                     last_step  = 1'b1;
                  end else begin
                     opnd2_d = shift_nxt;
                     cnt_d   = cnt_q - 4'd1;
                     // Overflow is sticky across the steps of a left shift.
                     if (op_q == OP_SHL && bus.alu_ov2)
                        rsp_ov_d = 1'b1;
`ifdef ALU_SEQ_EARLY_TERM_EN
                     last_step = (cnt_q == 4'd1) || (shift_nxt == 8'h00);
`else
                     last_step = (cnt_q == 4'd1);
`endif
                     if (last_step)
                        rsp_data_d = shift_nxt;
                  end
               end
               OP_MUL: begin
                  acc_d   = acc_nxt;
                  mcand_d = bus.alu_shl;
                  mult_d  = mult_nxt;
                  cnt_d   = cnt_q - 4'd1;
                  // The product exceeds 8 bits if an accepted add carries.
                  // It also does if a multiplicand bit is shifted out while
                  // multiplier bits remain that could still add it in.
                  if ((mult_q[0] && bus.alu_add[8]) ||
                      (bus.alu_ov2 && mult_nxt != 8'h00))
                     rsp_ov_d = 1'b1;
`ifdef ALU_SEQ_EARLY_TERM_EN
                  last_step = (cnt_q == 4'd1) || (mult_nxt == 8'h00);
`else
                  last_step = (cnt_q == 4'd1);
`endif
                  if (last_step)
                     rsp_data_d = acc_nxt;
               end
               default: begin
                  rsp_data_d = 8'h00;
                  rsp_err_d  = 1'b1;
                  last_step  = 1'b1;
               end
            endcase
            if (last_step)
               state_d = ST_DONE;
         end

         ST_DONE: begin
            if (bus.rsp_ready)
               state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      // The operand buses are registered and follow next-cycle operand state.
      // The ALU therefore sees the operands for the step it performs.
      alu_in1_d = (op_d == OP_MUL) ? acc_d   : opnd1_d;
      alu_in2_d = (op_d == OP_MUL) ? mcand_d : opnd2_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= 3'd0;
         opnd1_q     <= 8'h00;
         opnd2_q     <= 8'h00;
         cnt_q       <= 4'd0;
         acc_q       <= 8'h00;
         mcand_q     <= 8'h00;
         mult_q      <= 8'h00;
         alu_in1_q   <= 8'h00;
         alu_in2_q   <= 8'h00;
         rsp_data_q  <= 8'h00;
         rsp_carry_q <= 1'b0;
         rsp_ov_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         opnd1_q     <= opnd1_d;
         opnd2_q     <= opnd2_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mult_q      <= mult_d;
         alu_in1_q   <= alu_in1_d;
         alu_in2_q   <= alu_in2_d;
         rsp_data_q  <= rsp_data_d;
         rsp_carry_q <= rsp_carry_d;
         rsp_ov_q    <= rsp_ov_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = (state_q == ST_DONE);
   assign busy          = (state_q == ST_EXEC) || (state_q == ST_DONE);
   assign bus.alu_in1   = alu_in1_q;
   assign bus.alu_in2   = alu_in2_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_carry = rsp_carry_q;
   assign bus.rsp_ov    = rsp_ov_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Directed bench for alu_op_sequencer. A behavioural model of the
//   combinational ALU closes the loop on the operand buses. Expected results
//   are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic busy;
   int   n_cmp = 0;
   int   n_err = 0;

   alu_op_sequencer_if ifc ();

   alu_op_sequencer #(.MAX_SHIFT(7)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   // Combinational ALU model. The shifter works on input_2, and COMP
   // complements input_1.
   assign ifc.alu_add  = {1'b0, ifc.alu_in1} + {1'b0, ifc.alu_in2};
   assign ifc.alu_shl  = ifc.alu_in2 << 1;
   assign ifc.alu_shr  = ifc.alu_in2 >> 1;
   assign ifc.alu_and  = ifc.alu_in1 & ifc.alu_in2;
   assign ifc.alu_or   = ifc.alu_in1 | ifc.alu_in2;
   assign ifc.alu_comp = ~ifc.alu_in1;
   assign ifc.alu_ov2  = ifc.alu_in2[7];

`ifdef ALU_SEQ_EARLY_TERM_EN
   localparam int LAT_MUL_0F11 = 6;
   localparam int LAT_MUL_1010 = 6;
   localparam int LAT_MUL_B01  = 2;
   localparam int LAT_SHR_0ZERO = 3;
`else
   localparam int LAT_MUL_0F11 = 9;
   localparam int LAT_MUL_1010 = 9;
   localparam int LAT_MUL_B01  = 9;
   localparam int LAT_SHR_0ZERO = 6;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one request with rsp_ready already high. It measures the
   // accept-to-rsp_valid latency and checks the response and the return to
   // IDLE. Entry and exit are 1 time unit after a rising edge.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] cnt, input int lat,
                         input logic [7:0] d, input logic c, input logic ov, input logic err);
      int n;
      chk({tag, ".req_ready"}, ifc.req_ready, 1);
      ifc.req_valid = 1'b1;
      ifc.req_op    = op;
      ifc.req_a     = a;
      ifc.req_b     = b;
      ifc.req_cnt   = cnt;
      ifc.rsp_ready = 1'b1;
      @(posedge clk); #1;
      ifc.req_valid = 1'b0;
      n = 1;
      while (!ifc.rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ".lat"}, n, lat);
      chk({tag, ".data"}, ifc.rsp_data, d);
      chk({tag, ".carry"}, ifc.rsp_carry, c);
      chk({tag, ".ov"}, ifc.rsp_ov, ov);
      chk({tag, ".err"}, ifc.rsp_err, err);
      chk({tag, ".busy"}, busy, 1);
      @(posedge clk); #1;
      chk({tag, ".rsp_drop"}, ifc.rsp_valid, 0);
      chk({tag, ".ready_back"}, ifc.req_ready, 1);
   endtask

   initial begin
      int n;
      ifc.req_valid = 1'b0;
      ifc.req_op    = 3'd0;
      ifc.req_a     = 8'h00;
      ifc.req_b     = 8'h00;
      ifc.req_cnt   = 3'd0;
      ifc.rsp_ready = 1'b0;

      // Reset state
      #1;
      chk("rst.req_ready", ifc.req_ready, 1);
      chk("rst.rsp_valid", ifc.rsp_valid, 0);
      chk("rst.busy", busy, 0);
      chk("rst.outs", {ifc.rsp_data, ifc.rsp_carry, ifc.rsp_ov, ifc.rsp_err}, 0);
      chk("rst.alu_in", {ifc.alu_in1, ifc.alu_in2}, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      //     tag       op    a      b      cnt   lat            data   c  ov err
      run_op("add",   3'd0, 8'hC8, 8'h64, 3'd0, 2,             8'h2C, 1, 0, 0);
      run_op("shl3",  3'd1, 8'h55, 8'h81, 3'd3, 4,             8'h08, 0, 1, 0);
      run_op("shl0",  3'd1, 8'h55, 8'h81, 3'd0, 2,             8'h81, 0, 0, 0);
      run_op("shl7",  3'd1, 8'h00, 8'h01, 3'd7, 8,             8'h80, 0, 0, 0);
      run_op("shr2",  3'd2, 8'h00, 8'hF0, 3'd2, 3,             8'h3C, 0, 0, 0);
      run_op("shr7",  3'd2, 8'h00, 8'h80, 3'd7, 8,             8'h01, 0, 0, 0);
      run_op("shrz",  3'd2, 8'h00, 8'h02, 3'd5, LAT_SHR_0ZERO, 8'h00, 0, 0, 0);
      run_op("mul1",  3'd6, 8'h0F, 8'h11, 3'd0, LAT_MUL_0F11,  8'hFF, 0, 0, 0);
      run_op("mul2",  3'd6, 8'h10, 8'h10, 3'd0, LAT_MUL_1010,  8'h00, 0, 1, 0);
      run_op("mulb1", 3'd6, 8'h37, 8'h01, 3'd0, LAT_MUL_B01,   8'h37, 0, 0, 0);
      run_op("comp",  3'd5, 8'h5A, 8'h00, 3'd0, 2,             8'hA5, 0, 0, 0);
      run_op("rsvd",  3'd7, 8'h12, 8'h34, 3'd0, 2,             8'h00, 0, 0, 1);

      // Backpressure: AND held in DONE while a new request waits
      ifc.rsp_ready = 1'b0;
      ifc.req_valid = 1'b1;
      ifc.req_op = 3'd3; ifc.req_a = 8'hF0; ifc.req_b = 8'h3C;
      @(posedge clk); #1;
      ifc.req_op = 3'd4; ifc.req_a = 8'h01; ifc.req_b = 8'h02;
      n = 1;
      while (!ifc.rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp.lat", n, 2);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp.valid_hold", ifc.rsp_valid, 1);
         chk("bp.data_hold", ifc.rsp_data, 8'h30);
         chk("bp.no_accept", ifc.req_ready, 0);
      end
      ifc.req_valid = 1'b0;
      ifc.rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp.rsp_drop", ifc.rsp_valid, 0);
      chk("bp.ready_back", ifc.req_ready, 1);

      // Reset during the 4th EXEC cycle of a MUL
      ifc.req_valid = 1'b1;
      ifc.req_op = 3'd6; ifc.req_a = 8'h0F; ifc.req_b = 8'h11;
      @(posedge clk); #1;
      ifc.req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mrst.busy", busy, 0);
      chk("mrst.req_ready", ifc.req_ready, 1);
      chk("mrst.rsp_valid", ifc.rsp_valid, 0);
      chk("mrst.outs", {ifc.rsp_data, ifc.rsp_carry, ifc.rsp_ov, ifc.rsp_err}, 0);
      chk("mrst.alu_in", {ifc.alu_in1, ifc.alu_in2}, 0);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("mrst.no_rsp", ifc.rsp_valid, 0);
      run_op("or",    3'd4, 8'h0A, 8'h50, 3'd0, 2,             8'h5A, 0, 0, 0);
      run_op("mul0",  3'd6, 8'hAB, 8'h00, 3'd0, LAT_MUL_B01,   8'h00, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
